// File: rtl/click_decoder.sv
// click_decoder: groups one-cycle debounced press pulses into multi-click gestures.
// Optional macro CLICK_EARLY_EMIT_EN: report as soon as MAX_CLICKS is reached.
module click_decoder #(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter int unsigned WINDOW_MS  = 300,
  parameter int unsigned MAX_CLICKS = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pressed_i,
  output logic                              click_valid,
  output logic [$clog2(MAX_CLICKS+1)-1:0]   click_count,
  output logic                              busy
);

  localparam int unsigned WINDOW_CYCLES = (CLK_HZ / 1000) * WINDOW_MS;
  localparam int unsigned TMR_W         = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned CNT_W         = $clog2(MAX_CLICKS + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CLICKS);

  typedef enum logic {IDLE, COUNTING} state_t;

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_click_count;
  logic             r_valid;
  logic             r_busy;
  logic [CNT_W-1:0] w_count_inc;

  assign w_count_inc = r_count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_timer       <= '0;
      r_count       <= '0;
      r_click_count <= '0;
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (pressed_i) begin
`ifdef CLICK_EARLY_EMIT_EN
            if (MAX_CLICKS == 1) begin
              r_valid       <= 1'b1;
              r_click_count <= CNT_MAX;
            end else begin
              r_state <= COUNTING;
              r_busy  <= 1'b1;
              r_count <= CNT_W'(1);
              r_timer <= '0;
            end
`else
            r_state <= COUNTING;
            r_busy  <= 1'b1;
            r_count <= CNT_W'(1);
            r_timer <= '0;
`endif
          end
        end
        COUNTING: begin
          // A press always beats a coinciding timeout: it restarts the window.
          if (pressed_i) begin
            r_timer <= '0;
`ifdef CLICK_EARLY_EMIT_EN
            if (w_count_inc == CNT_MAX) begin
              r_valid       <= 1'b1;
              r_click_count <= CNT_MAX;
              r_state       <= IDLE;
              r_busy        <= 1'b0;
              r_count       <= '0;
            end else begin
              r_count <= w_count_inc;
            end
`else
            if (r_count < CNT_MAX) r_count <= w_count_inc;
`endif
          end else if (r_timer == TMR_LAST) begin
            r_valid       <= 1'b1;
            r_click_count <= r_count;
            r_state       <= IDLE;
            r_busy        <= 1'b0;
            r_count       <= '0;
            r_timer       <= '0;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign click_valid = r_valid;
  assign click_count = r_click_count;
  assign busy        = r_busy;

endmodule

// File: tb/tb_click_decoder.sv
// Directed bench for click_decoder: per-scenario press/reset masks, expected strobes in a queue.
module tb_click_decoder;

  localparam int unsigned NCYC = 35;

  logic       clk = 1'b0;
  logic       rst;
  logic       pressed_i;
  logic       click_valid;
  logic [1:0] click_count;
  logic       busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct {
    int unsigned e;
    logic [1:0]  c;
  } exp_t;

  exp_t q[$];

  click_decoder #(
    .CLK_HZ    (10_000),
    .WINDOW_MS (1),
    .MAX_CLICKS(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pressed_i  (pressed_i),
    .click_valid(click_valid),
    .click_count(click_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int unsigned e, input logic [1:0] c);
    exp_t x;
    x.e = e;
    x.c = c;
    q.push_back(x);
  endtask

  // Edge k of a scenario samples pm[k] / rm[k]; outputs checked #1 after that edge.
  task automatic run_scn(input string name, input logic [63:0] pm, input logic [63:0] rm);
    logic exp_v;
    logic mbusy;
    exp_t f;
    mbusy = 1'b0;
    for (int unsigned k = 0; k < NCYC; k++) begin
      @(negedge clk);
      pressed_i = pm[k];
      rst       = rm[k];
      @(posedge clk);
      #1;
      exp_v = (q.size() > 0) && (q[0].e == k);
      if (rm[k])      mbusy = 1'b0;
      else if (exp_v) mbusy = 1'b0;
      else if (pm[k]) mbusy = 1'b1;
      check($sformatf("%s valid@%0d", name, k), {31'd0, click_valid}, {31'd0, exp_v});
      check($sformatf("%s busy@%0d", name, k), {31'd0, busy}, {31'd0, mbusy});
      if (exp_v) begin
        f = q.pop_front();
        check($sformatf("%s count@%0d", name, k), {30'd0, click_count}, {30'd0, f.c});
      end
    end
    @(negedge clk);
    pressed_i = 1'b0;
    rst       = 1'b0;
    check($sformatf("%s pending", name), q.size(), 0);
    q.delete();
  endtask

  initial begin
    rst       = 1'b1;
    pressed_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid", {31'd0, click_valid}, 0);
    check("reset count", {30'd0, click_count}, 0);
    check("reset busy",  {31'd0, busy}, 0);
    @(negedge clk);
    rst = 1'b0;

    push(15, 2'd1);
    run_scn("single", 64'd1 << 5, '0);

    push(22, 2'd2);
    run_scn("double", (64'd1 << 5) | (64'd1 << 12), '0);

    push(25, 2'd2);
    run_scn("press_at_timeout", (64'd1 << 5) | (64'd1 << 15), '0);

`ifdef CLICK_EARLY_EMIT_EN
    push(11, 2'd3);
    push(24, 2'd1);
`else
    push(24, 2'd3);
`endif
    run_scn("four", (64'd1 << 5) | (64'd1 << 8) | (64'd1 << 11) | (64'd1 << 14), '0);

    run_scn("reset_mid", 64'd1 << 5, 64'd1 << 9);

    push(15, 2'd1);
    push(26, 2'd1);
    run_scn("gap11", (64'd1 << 5) | (64'd1 << 16), '0);

`ifdef CLICK_EARLY_EMIT_EN
    push(6, 2'd3);
    push(20, 2'd2);
`else
    push(20, 2'd3);
`endif
    run_scn("five", (64'd1 << 2) | (64'd1 << 4) | (64'd1 << 6) | (64'd1 << 8) | (64'd1 << 10), '0);

    push(12, 2'd1);
    push(23, 2'd1);
    run_scn("after_emit", (64'd1 << 2) | (64'd1 << 13), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
